// File: rtl/alarm_mode_ctrl.sv
// alarm_mode_ctrl: car-alarm supervisor.
// Arms/disarms on key edges, watches door and shock sensors, and drives the
// led_run effect select (00 off, 01 armed chase, 10 flash burst, 11 alarm)
// together with the siren enable. All board inputs are asynchronous levels.
module alarm_mode_ctrl #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned ACK_CYCLES   = 8,
  parameter int unsigned ENTRY_CYCLES = 20,
  parameter int unsigned ALARM_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arm_req,
  input  logic       disarm_req,
  input  logic       door_open,
  input  logic       shock,
  output logic [1:0] enable,
  output logic       siren,
  output logic       armed
);

  // Dwell limits must fit the counter so it can never wrap.
  if (ACK_CYCLES < 1 || ACK_CYCLES >= (2 ** CNT_W) ||
      ENTRY_CYCLES < 1 || ENTRY_CYCLES >= (2 ** CNT_W) ||
      ALARM_CYCLES < 1 || ALARM_CYCLES >= (2 ** CNT_W)) begin : g_bad_limits
    $error("alarm_mode_ctrl: dwell limits must be in 1..2**CNT_W-1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM_ACK,
    S_ARMED,
    S_ENTRY,
    S_ALARM,
    S_DISARM_ACK
  } state_t;

  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ENTRY_LAST = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_CYCLES - 1);

  // Synchronizer bit order: {shock, door_open, disarm_req, arm_req}
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [1:0] fill;
  logic       arm_prev;
  logic       disarm_prev;

  logic       arm_s;
  logic       disarm_s;
  logic       door_s;
  logic       shock_s;
  logic       arm_edge;
  logic       disarm_edge;

  state_t           state;
  state_t           next_state;
  logic             restart;
  logic             timed;
  logic [CNT_W-1:0] cnt;

  logic [1:0] enable_d;
  logic       siren_d;
  logic       armed_d;

  assign arm_s    = sync2[0];
  assign disarm_s = sync2[1];
  assign door_s   = sync2[2];
  assign shock_s  = sync2[3];

  assign arm_edge    = arm_s & ~arm_prev;
  assign disarm_edge = disarm_s & ~disarm_prev;

  // Two-flop synchronizers on all four board inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {shock, door_open, disarm_req, arm_req};
      sync2 <= sync1;
    end
  end

  // Key edge history. The synchronizer output is not a real sample until two
  // clocks after reset, so history stays forced high until then; a key held
  // through reset release therefore never produces an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill        <= '0;
      arm_prev    <= 1'b1;
      disarm_prev <= 1'b1;
    end else begin
      fill        <= {fill[0], 1'b1};
      arm_prev    <= fill[1] ? arm_s : 1'b1;
      disarm_prev <= fill[1] ? disarm_s : 1'b1;
    end
  end

  assign timed = (state != S_IDLE) && (state != S_ARMED);

  // State register, dwell counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      enable <= '0;
      siren  <= 1'b0;
      armed  <= 1'b0;
    end else begin
      state  <= next_state;
      enable <= enable_d;
      siren  <= siren_d;
      armed  <= armed_d;
      if ((next_state != state) || restart) begin
        cnt <= '0;
      end else if (timed) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Next-state logic; priority disarm > shock > door > timer expiry.
  always_comb begin
    next_state = state;
    restart    = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm_edge) next_state = S_ARM_ACK;
      end
      S_ARM_ACK: begin
        if (disarm_edge)          next_state = S_DISARM_ACK;
        else if (cnt == ACK_LAST) next_state = S_ARMED;
      end
      S_ARMED: begin
        if (disarm_edge)  next_state = S_DISARM_ACK;
        else if (shock_s) next_state = S_ALARM;
        else if (door_s)  next_state = S_ENTRY;
      end
      S_ENTRY: begin
        if (disarm_edge)            next_state = S_DISARM_ACK;
        else if (shock_s)           next_state = S_ALARM;
        else if (cnt == ENTRY_LAST) next_state = S_ALARM;
      end
      S_ALARM: begin
        if (disarm_edge) begin
          next_state = S_DISARM_ACK;
        end else if (cnt == ALARM_LAST) begin
          // Re-trigger stays in ALARM with a fresh period; enable holds 11.
          if (door_s || shock_s) restart    = 1'b1;
          else                   next_state = S_ARMED;
        end
      end
      S_DISARM_ACK: begin
        if (cnt == ACK_LAST) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode from the next state so outputs move with the state.
  always_comb begin
    enable_d = 2'b00;
    siren_d  = 1'b0;
    armed_d  = 1'b0;
    case (next_state)
      S_ARM_ACK:    enable_d = 2'b10;
      S_ARMED: begin
        enable_d = 2'b01;
        armed_d  = 1'b1;
      end
      S_ENTRY: begin
        enable_d = 2'b01;
        armed_d  = 1'b1;
      end
      S_ALARM: begin
        enable_d = 2'b11;
        siren_d  = 1'b1;
        armed_d  = 1'b1;
      end
      S_DISARM_ACK: enable_d = 2'b10;
      default: begin
        enable_d = 2'b00;
        siren_d  = 1'b0;
        armed_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Testbench for alarm_mode_ctrl: directed scenarios plus randomized key and
// sensor activity, compared every cycle against a behavioural model that
// counts remaining dwell cycles and looks up delayed input samples.
module tb_alarm_mode_ctrl;

  localparam int ACK_N   = 8;
  localparam int ENTRY_N = 20;
  localparam int ALARM_N = 64;

  logic       clk;
  logic       reset;
  logic       arm_req;
  logic       disarm_req;
  logic       door_open;
  logic       shock;
  logic [1:0] enable;
  logic       siren;
  logic       armed;

  int n_checks;
  int n_pass;

  alarm_mode_ctrl #(
    .CNT_W       (8),
    .ACK_CYCLES  (ACK_N),
    .ENTRY_CYCLES(ENTRY_N),
    .ALARM_CYCLES(ALARM_N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .arm_req   (arm_req),
    .disarm_req(disarm_req),
    .door_open (door_open),
    .shock     (shock),
    .enable    (enable),
    .siren     (siren),
    .armed     (armed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_ARM_ACK, M_ARMED, M_ENTRY, M_ALARM, M_DISARM_ACK} mmode_t;

  mmode_t mode;
  int     left;   // cycles still to spend in a timed mode
  int     k;      // clock edges since reset release
  bit     qa[$], qd[$], qo[$], qs[$];

  function automatic int limit_of(mmode_t m);
    case (m)
      M_ARM_ACK, M_DISARM_ACK: return ACK_N;
      M_ENTRY:                 return ENTRY_N;
      M_ALARM:                 return ALARM_N;
      default:                 return 0;
    endcase
  endfunction

  function automatic logic [3:0] exp_out(mmode_t m);
    // {enable, siren, armed}
    case (m)
      M_ARM_ACK, M_DISARM_ACK: return 4'b1000;
      M_ARMED, M_ENTRY:        return 4'b0101;
      M_ALARM:                 return 4'b1111;
      default:                 return 4'b0000;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    bit     ae, de, dl, sl, rs;
    mmode_t nm;
    if (!reset) begin
      mode = M_IDLE;
      left = 0;
      k    = 0;
      qa.delete(); qd.delete(); qo.delete(); qs.delete();
    end else begin
      qa.push_back(arm_req);    if (qa.size() > 4) void'(qa.pop_front());
      qd.push_back(disarm_req); if (qd.size() > 4) void'(qd.pop_front());
      qo.push_back(door_open);  if (qo.size() > 4) void'(qo.pop_front());
      qs.push_back(shock);      if (qs.size() > 4) void'(qs.pop_front());
      // A decision sees inputs sampled two edges earlier; edges need a
      // genuine earlier low sample, so nothing counts before the third edge.
      ae = (k >= 3) && qa[qa.size()-3] && !qa[qa.size()-4];
      de = (k >= 3) && qd[qd.size()-3] && !qd[qd.size()-4];
      dl = (k >= 2) && qo[qo.size()-3];
      sl = (k >= 2) && qs[qs.size()-3];
      nm = mode;
      rs = 0;
      case (mode)
        M_IDLE:       if (ae) nm = M_ARM_ACK;
        M_ARM_ACK:    if (de) nm = M_DISARM_ACK; else if (left == 1) nm = M_ARMED;
        M_ARMED:      if (de) nm = M_DISARM_ACK; else if (sl) nm = M_ALARM; else if (dl) nm = M_ENTRY;
        M_ENTRY:      if (de) nm = M_DISARM_ACK; else if (sl || left == 1) nm = M_ALARM;
        M_ALARM:      if (de) nm = M_DISARM_ACK;
                      else if (left == 1) begin
                        if (dl || sl) rs = 1; else nm = M_ARMED;
                      end
        M_DISARM_ACK: if (left == 1) nm = M_IDLE;
        default:      nm = M_IDLE;
      endcase
      if (nm != mode || rs) left = limit_of(nm);
      else if (left > 0) left = left - 1;
      mode = nm;
      if (k < 1000) k++;
    end
  end

  // ---------------- per-cycle comparison ----------------
  bit checking;
  always @(negedge clk) begin
    if (checking) check_eq("outputs", {enable, siren, armed}, exp_out(mode));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 3) arm_req    = ~arm_req;
      if ($urandom_range(0, 99) < 2) disarm_req = ~disarm_req;
      if ($urandom_range(0, 99) < 3) door_open  = ~door_open;
      if ($urandom_range(0, 99) < 2) shock      = ~shock;
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    checking   = 0;
    reset      = 1'b0;
    arm_req    = 1'b1;   // held through reset release: must not arm
    disarm_req = 1'b0;
    door_open  = 1'b0;
    shock      = 1'b0;
    cycles(3);
    checking = 1;
    cycles(1);
    reset = 1'b1;
    cycles(12);
    check_eq("held_arm_no_arm", {30'd0, enable}, 32'd0);
    arm_req = 1'b0;
    cycles(100);
    check_eq("idle_after_100", {enable, siren, armed}, 4'b0000);

    // Arm pulse and acknowledge burst.
    arm_req = 1'b1; cycles(1); arm_req = 1'b0;
    cycles(5);
    check_eq("arm_ack_burst", {30'd0, enable}, 32'd2);
    cycles(25);
    check_eq("armed_chase", {enable, siren, armed}, 4'b0101);

    // Door opens, entry delay expires, alarm runs its period, back to armed.
    door_open = 1'b1; cycles(4); door_open = 1'b0;
    cycles(24);
    check_eq("entry_to_alarm", {enable, siren, armed}, 4'b1111);
    cycles(70);
    check_eq("alarm_to_armed", {enable, siren, armed}, 4'b0101);

    // Disarm during entry.
    door_open = 1'b1; cycles(10); door_open = 1'b0;
    disarm_req = 1'b1; cycles(1); disarm_req = 1'b0;
    cycles(4);
    check_eq("entry_disarm_ack", {30'd0, enable}, 32'd2);
    cycles(15);
    check_eq("disarmed_idle", {enable, siren, armed}, 4'b0000);

    // Shock and disarm on the same edge: disarm wins.
    arm_req = 1'b1; cycles(1); arm_req = 1'b0;
    cycles(15);
    shock = 1'b1; disarm_req = 1'b1; cycles(2);
    shock = 1'b0; disarm_req = 1'b0;
    cycles(2);
    check_eq("shock_disarm_siren", {31'd0, siren}, 32'd0);
    cycles(15);

    random_phase(3000);

    // Reset pulse during ALARM acts immediately.
    arm_req = 1'b0; disarm_req = 1'b0; door_open = 1'b0; shock = 1'b0;
    cycles(20);
    arm_req = 1'b1; cycles(1); arm_req = 1'b0;
    cycles(15);
    shock = 1'b1; cycles(1); shock = 1'b0;
    for (int i = 0; i < 20 && mode != M_ALARM; i++) cycles(1);
    check_eq("reached_alarm", {31'd0, siren}, 32'd1);
    #2 reset = 1'b0;
    #1 check_eq("async_reset", {enable, siren, armed}, 4'b0000);
    cycles(2);
    reset = 1'b1;
    cycles(10);

    random_phase(1500);

    checking = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
